// File: rtl/latency_bucket_dump_ctrl_if.sv
// rtl/latency_bucket_dump_ctrl_if.sv - record stream from the dump controller to the host sink
interface latency_bucket_dump_ctrl_if #(
    parameter int UNIT_W = 2
);
    logic              io_out_valid;
    logic              io_out_ready;
    logic [UNIT_W-1:0] io_out_unit;
    logic [4:0]        io_out_bucket;
    logic [31:0]       io_out_data;
    logic              io_out_last;

    modport master (
        output io_out_valid, io_out_unit, io_out_bucket, io_out_data, io_out_last,
        input  io_out_ready
    );

    modport slave (
        input  io_out_valid, io_out_unit, io_out_bucket, io_out_data, io_out_last,
        output io_out_ready
    );
endinterface

// File: rtl/latency_bucket_dump_ctrl.sv
// rtl/latency_bucket_dump_ctrl.sv - quiesce, sweep, stream and clear an array of latency-bucket units
module latency_bucket_dump_ctrl #(
    parameter int NUM_UNITS    = 4,
    parameter int NUM_BUCKETS  = 32,
    parameter int RD_LAT       = 1,
    parameter int DRAIN_CYCLES = 8,
    parameter int CLR_TIMEOUT  = 1024
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      io_enableCfg,
    input  logic                      io_dumpReq,
    input  logic                      io_dumpClear,
    input  logic                      io_clearReq,
    output logic                      io_busy,
    output logic                      io_done,
    output logic                      io_error,
    output logic [NUM_UNITS-1:0]      io_bucketEnable,
    output logic [4:0]                io_bucketRdId,
    input  logic [NUM_UNITS*32-1:0]   io_bucketValue,
    output logic [NUM_UNITS-1:0]      io_bucketReset,
    input  logic [NUM_UNITS-1:0]      io_bucketResetDone,
    latency_bucket_dump_ctrl_if.master out_if
);
    localparam int UNIT_W   = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
    localparam int CNT_MAX0 = (DRAIN_CYCLES > RD_LAT) ? DRAIN_CYCLES : RD_LAT;
    localparam int CNT_MAX  = (CLR_TIMEOUT > CNT_MAX0) ? CLR_TIMEOUT : CNT_MAX0;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE, QUIESCE, READ_WAIT, EMIT, ADVANCE, CLEAR, CLEAR_WAIT, FINISH
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [UNIT_W-1:0]     unit_q, unit_d;
    logic [4:0]            bucket_q, bucket_d;
    logic                  do_dump_q, do_dump_d;
    logic                  do_clear_q, do_clear_d;
    logic                  error_q, error_d;
    logic [NUM_UNITS-1:0]  enable_q, enable_d;
    logic [NUM_UNITS-1:0]  sticky_q, sticky_d;
    logic [UNIT_W-1:0]     out_unit_q, out_unit_d;
    logic [4:0]            out_bucket_q, out_bucket_d;
    logic [31:0]           out_data_q, out_data_d;
    logic                  out_last_q, out_last_d;
    logic [31:0]           sel_value;
    logic                  at_last;

    always_comb begin
        sel_value = '0;
        for (int u = 0; u < NUM_UNITS; u++) begin
            if (unit_q == UNIT_W'(u)) sel_value = io_bucketValue[32*u +: 32];
        end
    end

    assign at_last = (unit_q == UNIT_W'(NUM_UNITS - 1)) && (bucket_q == 5'(NUM_BUCKETS - 1));

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        unit_d       = unit_q;
        bucket_d     = bucket_q;
        do_dump_d    = do_dump_q;
        do_clear_d   = do_clear_q;
        error_d      = error_q;
        sticky_d     = sticky_q;
        out_unit_d   = out_unit_q;
        out_bucket_d = out_bucket_q;
        out_data_d   = out_data_q;
        out_last_d   = out_last_q;
        case (state_q)
            IDLE: begin
                if (io_dumpReq || io_clearReq) begin
                    state_d    = QUIESCE;
                    cnt_d      = '0;
                    do_dump_d  = io_dumpReq;
                    do_clear_d = io_dumpClear | io_clearReq;
                    error_d    = 1'b0;
                end
            end
            QUIESCE: begin
                if (cnt_q == CNT_W'(DRAIN_CYCLES - 1)) begin
                    cnt_d = '0;
                    if (do_dump_q) begin
                        unit_d   = '0;
                        bucket_d = '0;
                        state_d  = READ_WAIT;
                    end else begin
                        state_d  = CLEAR;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            READ_WAIT: begin
                if (cnt_q == CNT_W'(RD_LAT - 1)) begin
                    cnt_d        = '0;
                    out_unit_d   = unit_q;
                    out_bucket_d = bucket_q;
                    out_data_d   = sel_value;
                    out_last_d   = at_last;
                    state_d      = EMIT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            EMIT: begin
                if (out_if.io_out_ready) state_d = ADVANCE;
            end
            ADVANCE: begin
                if (bucket_q == 5'(NUM_BUCKETS - 1)) begin
                    bucket_d = '0;
                    unit_d   = at_last ? '0 : unit_q + UNIT_W'(1);
                end else begin
                    bucket_d = bucket_q + 5'd1;
                end
                if (at_last) state_d = do_clear_q ? CLEAR : FINISH;
                else         state_d = READ_WAIT;
            end
            CLEAR: begin
                sticky_d = '0;
                cnt_d    = '0;
                state_d  = CLEAR_WAIT;
            end
            CLEAR_WAIT: begin
                // Done flags may be level or pulse; the sticky capture handles both.
                sticky_d = sticky_q | io_bucketResetDone;
                if (&sticky_d) begin
                    state_d = FINISH;
                end else if (cnt_q == CNT_W'(CLR_TIMEOUT - 1)) begin
                    error_d = 1'b1;
                    state_d = FINISH;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        enable_d = (state_d == IDLE) ? {NUM_UNITS{io_enableCfg}} : '0;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            unit_q       <= '0;
            bucket_q     <= '0;
            do_dump_q    <= 1'b0;
            do_clear_q   <= 1'b0;
            error_q      <= 1'b0;
            enable_q     <= '0;
            sticky_q     <= '0;
            out_unit_q   <= '0;
            out_bucket_q <= '0;
            out_data_q   <= '0;
            out_last_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            unit_q       <= unit_d;
            bucket_q     <= bucket_d;
            do_dump_q    <= do_dump_d;
            do_clear_q   <= do_clear_d;
            error_q      <= error_d;
            enable_q     <= enable_d;
            sticky_q     <= sticky_d;
            out_unit_q   <= out_unit_d;
            out_bucket_q <= out_bucket_d;
            out_data_q   <= out_data_d;
            out_last_q   <= out_last_d;
        end
    end

    assign io_busy             = (state_q != IDLE);
    assign io_done             = (state_q == FINISH);
    assign io_error            = error_q;
    assign io_bucketEnable     = enable_q;
    assign io_bucketRdId       = bucket_q;
    assign io_bucketReset      = (state_q == CLEAR) ? {NUM_UNITS{1'b1}} : '0;
    assign out_if.io_out_valid  = (state_q == EMIT);
    assign out_if.io_out_unit   = out_unit_q;
    assign out_if.io_out_bucket = out_bucket_q;
    assign out_if.io_out_data   = out_data_q;
    assign out_if.io_out_last   = out_last_q;
endmodule

// File: tb/tb_latency_bucket_dump_ctrl.sv
// tb/tb_latency_bucket_dump_ctrl.sv - scoreboard bench for the latency bucket dump controller
module tb_latency_bucket_dump_ctrl;
    localparam int N      = 4;
    localparam int B      = 32;
    localparam int RD_LAT = 1;
    localparam int DRAIN  = 8;
    localparam int CLR_TO = 1024;
    localparam int UW     = 2;

    typedef struct packed {
        logic [UW-1:0] unit;
        logic [4:0]    bucket;
        logic [31:0]   data;
        logic          last;
    } rec_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic enable_cfg = 1'b1;
    logic dump_req = 1'b0;
    logic dump_clear = 1'b0;
    logic clear_req = 1'b0;
    logic busy, done, error;
    logic [N-1:0]    bucket_enable, bucket_reset;
    logic [N-1:0]    reset_done = '0;
    logic [4:0]      rd_id;
    logic [N*32-1:0] bucket_value;
    logic [31:0]     mem [N][B];

    int   checks = 0;
    int   errors = 0;
    int   rec_cnt = 0;
    int   done_cnt = 0;
    int   rst_pulse_cnt = 0;
    int   del [N];
    bit   bp_mode = 1'b0;
    rec_t exp_q [$];

    latency_bucket_dump_ctrl_if #(.UNIT_W(UW)) out_if ();

    latency_bucket_dump_ctrl #(
        .NUM_UNITS(N), .NUM_BUCKETS(B), .RD_LAT(RD_LAT),
        .DRAIN_CYCLES(DRAIN), .CLR_TIMEOUT(CLR_TO)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .io_enableCfg       (enable_cfg),
        .io_dumpReq         (dump_req),
        .io_dumpClear       (dump_clear),
        .io_clearReq        (clear_req),
        .io_busy            (busy),
        .io_done            (done),
        .io_error           (error),
        .io_bucketEnable    (bucket_enable),
        .io_bucketRdId      (rd_id),
        .io_bucketValue     (bucket_value),
        .io_bucketReset     (bucket_reset),
        .io_bucketResetDone (reset_done),
        .out_if             (out_if)
    );

    always #5 clock = ~clock;

    always_comb begin
        bucket_value = '0;
        for (int u = 0; u < N; u++) bucket_value[u*32 +: 32] = mem[u][rd_id];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Bucket units: done bit u rises del[u] cycles after the clear pulse; 0 means never.
    initial begin : resetdone_model
        int t;
        bit armed;
        t = 0;
        armed = 1'b0;
        forever begin
            @(posedge clock); #1;
            if (!reset) begin
                armed = 1'b0;
                reset_done = '0;
            end else if (bucket_reset != '0) begin
                reset_done = '0;
                t = 0;
                armed = 1'b1;
            end else if (armed) begin
                t++;
                for (int u = 0; u < N; u++)
                    if (del[u] > 0 && t == del[u]) reset_done[u] = 1'b1;
            end
        end
    end

    initial begin : ready_drv
        out_if.io_out_ready = 1'b1;
        forever begin
            @(posedge clock); #1;
            out_if.io_out_ready = bp_mode ? ($urandom_range(0, 2) == 0) : 1'b1;
        end
    end

    initial begin : monitor
        bit   hold;
        rec_t held, act;
        hold = 1'b0;
        held = '0;
        forever begin
            @(negedge clock);
            act.unit   = out_if.io_out_unit;
            act.bucket = out_if.io_out_bucket;
            act.data   = out_if.io_out_data;
            act.last   = out_if.io_out_last;
            if (!reset) begin
                hold = 1'b0;
            end else begin
                if (hold) begin
                    chk("bp_valid_held", 64'(out_if.io_out_valid), 64'd1);
                    chk("bp_payload_stable", 64'(act), 64'(held));
                end
                if (out_if.io_out_valid && out_if.io_out_ready) begin
                    chk("record_expected", 64'(exp_q.size() != 0), 64'd1);
                    if (exp_q.size() != 0) chk("record", 64'(act), 64'(exp_q.pop_front()));
                    rec_cnt++;
                end
                hold = out_if.io_out_valid && !out_if.io_out_ready;
                held = act;
                if (done) done_cnt++;
                if (bucket_reset != '0) begin
                    rst_pulse_cnt++;
                    chk("bucket_reset_all", 64'(bucket_reset), 64'hF);
                end
            end
        end
    end

    task automatic load_mem(input bit rnd);
        for (int u = 0; u < N; u++)
            for (int b = 0; b < B; b++)
                mem[u][b] = rnd ? $urandom : 32'(u * 256 + b);
    endtask

    task automatic push_dump();
        rec_t r;
        for (int u = 0; u < N; u++)
            for (int b = 0; b < B; b++) begin
                r.unit   = UW'(u);
                r.bucket = 5'(b);
                r.data   = mem[u][b];
                r.last   = (u == N - 1) && (b == B - 1);
                exp_q.push_back(r);
            end
    endtask

    task automatic request(input bit d, input bit dc, input bit c);
        @(posedge clock); #1;
        dump_req = d; dump_clear = dc; clear_req = c;
        @(posedge clock); #1;
        dump_req = 1'b0; dump_clear = 1'b0; clear_req = 1'b0;
    endtask

    task automatic wait_done(input string name, input int bound, output int cycles);
        cycles = 0;
        while (1) begin
            @(negedge clock);
            cycles++;
            if (done) break;
            if (cycles >= bound) begin
                chk({name, "_done_timeout"}, 64'(done), 64'd1);
                break;
            end
        end
    endtask

    task automatic wait_clear_pulse(input string name);
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (bucket_reset != '0) return;
        end
        chk({name, "_clear_pulse_timeout"}, 64'(bucket_reset), 64'hF);
    endtask

    task automatic end_check(input string name, input int d0, input int r0, input int recs);
        @(negedge clock);
        chk({name, "_idle"}, 64'(busy), 64'd0);
        chk({name, "_enable_back"}, 64'(bucket_enable), 64'hF);
        chk({name, "_records"}, 64'(rec_cnt - r0), 64'(recs));
        chk({name, "_one_done"}, 64'(done_cnt - d0), 64'd1);
        chk({name, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        int cyc, d0, r0, p0;
        for (int u = 0; u < N; u++) del[u] = 0;
        load_mem(1'b0);
        #1 reset = 1'b0;
        #2;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_error", 64'(error), 64'd0);
        chk("rst_valid", 64'(out_if.io_out_valid), 64'd0);
        chk("rst_enable", 64'(bucket_enable), 64'd0);
        chk("rst_bucket_reset", 64'(bucket_reset), 64'd0);
        chk("rst_rd_id", 64'(rd_id), 64'd0);
        #20;
        @(posedge clock); #1 reset = 1'b1;
        @(posedge clock); @(negedge clock);
        chk("enable_after_release", 64'(bucket_enable), 64'hF);

        // Dump without clear, ramp pattern, ready held high.
        load_mem(1'b0);
        push_dump();
        d0 = done_cnt; r0 = rec_cnt;
        request(1'b1, 1'b0, 1'b0);
        chk("t1_enable_drop", 64'(bucket_enable), 64'd0);
        chk("t1_busy", 64'(busy), 64'd1);
        wait_done("t1", 2000, cyc);
        chk("t1_duration", 64'(cyc), 64'(DRAIN + N * B * (RD_LAT + 2) + 1));
        end_check("t1", d0, r0, N * B);

        // Dump under random backpressure, random values.
        load_mem(1'b1);
        push_dump();
        d0 = done_cnt; r0 = rec_cnt;
        bp_mode = 1'b1;
        request(1'b1, 1'b0, 1'b0);
        wait_done("t2", 6000, cyc);
        bp_mode = 1'b0;
        end_check("t2", d0, r0, N * B);

        // Clear only with staggered done bits.
        del[0] = 3; del[1] = 5; del[2] = 9; del[3] = 12;
        d0 = done_cnt; r0 = rec_cnt; p0 = rst_pulse_cnt;
        request(1'b0, 1'b0, 1'b1);
        wait_clear_pulse("t3");
        wait_done("t3", 100, cyc);
        chk("t3_done_latency", 64'(cyc), 64'd13);
        chk("t3_error", 64'(error), 64'd0);
        end_check("t3", d0, r0, 0);
        chk("t3_one_pulse", 64'(rst_pulse_cnt - p0), 64'd1);

        // Clear timeout with unit 2 stuck.
        del[0] = 2; del[1] = 2; del[2] = 0; del[3] = 2;
        d0 = done_cnt; r0 = rec_cnt;
        request(1'b0, 1'b0, 1'b1);
        wait_clear_pulse("t4");
        wait_done("t4", CLR_TO + 50, cyc);
        chk("t4_done_latency", 64'(cyc), 64'(CLR_TO + 1));
        end_check("t4", d0, r0, 0);
        chk("t4_error_set", 64'(error), 64'd1);
        repeat (5) @(negedge clock);
        chk("t4_error_sticky", 64'(error), 64'd1);
        load_mem(1'b1);
        push_dump();
        d0 = done_cnt; r0 = rec_cnt;
        request(1'b1, 1'b0, 1'b0);
        chk("t4_error_cleared", 64'(error), 64'd0);
        wait_done("t4b", 2000, cyc);
        end_check("t4b", d0, r0, N * B);

        // Collision: dump+clear together, then a dropped dump request mid-operation.
        for (int u = 0; u < N; u++) del[u] = 2;
        load_mem(1'b1);
        push_dump();
        d0 = done_cnt; r0 = rec_cnt; p0 = rst_pulse_cnt;
        request(1'b1, 1'b0, 1'b1);
        repeat (50) @(negedge clock);
        request(1'b1, 1'b0, 1'b0);
        wait_done("t5", 2000, cyc);
        end_check("t5", d0, r0, N * B);
        chk("t5_clear_done", 64'(rst_pulse_cnt - p0), 64'd1);
        repeat (20) @(negedge clock);
        chk("t5_no_requeue", 64'(busy), 64'd0);
        chk("t5_still_one_done", 64'(done_cnt - d0), 64'd1);

        // Reset during record 40.
        load_mem(1'b0);
        push_dump();
        r0 = rec_cnt;
        request(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 1000 && (rec_cnt - r0) < 40; i++) @(negedge clock);
        chk("t6_reached_40", 64'(rec_cnt - r0), 64'd40);
        d0 = done_cnt;
        #2 reset = 1'b0;
        #1;
        chk("t6_valid_async", 64'(out_if.io_out_valid), 64'd0);
        chk("t6_busy_async", 64'(busy), 64'd0);
        chk("t6_bucket_reset_async", 64'(bucket_reset), 64'd0);
        chk("t6_done_async", 64'(done), 64'd0);
        exp_q.delete();
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock); @(negedge clock);
        chk("t6_enable_follows", 64'(bucket_enable), 64'hF);
        chk("t6_no_done", 64'(done_cnt - d0), 64'd0);
        enable_cfg = 1'b0;
        @(posedge clock); @(negedge clock);
        chk("t6_enable_cfg_low", 64'(bucket_enable), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
